// File: rtl/kws_reset_sequencer.sv
// kws_reset_sequencer: staged active-low subsystem reset generator for the
// sys_clk domain. It runs a full release sequence after power-on reset. It
// also runs masked soft-reset sequences on request. Requests that arrive
// while a sequence is running are queued and coalesced into a single rerun.
module kws_reset_sequencer #(
  parameter int N_RST_OUT      = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int GAP_CYCLES     = 8,
  parameter int CNT_WIDTH      = 8,
  parameter int SRST_CNT_WIDTH = 8
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      soft_rst_req,
  input  logic [N_RST_OUT-1:0]      soft_rst_mask,
  output logic [N_RST_OUT-1:0]      rst_n_out,
  output logic                      seq_busy,
  output logic                      seq_done,
  output logic [SRST_CNT_WIDTH-1:0] soft_rst_cnt
);

  localparam int IDX_W = (N_RST_OUT > 1) ? $clog2(N_RST_OUT) : 1;

  localparam logic [CNT_WIDTH-1:0] STRETCH_LAST = CNT_WIDTH'(STRETCH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST     = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST     = IDX_W'(N_RST_OUT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      timer_q, timer_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [N_RST_OUT-1:0]      act_mask_q, act_mask_d;
  logic                      pend_q, pend_d;
  logic [N_RST_OUT-1:0]      pend_mask_q, pend_mask_d;
  logic [N_RST_OUT-1:0]      rst_n_q, rst_n_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [SRST_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // A request with an empty mask is a no-op in every state.
  logic                      req_valid;
  logic [N_RST_OUT-1:0]      rerun_mask;
  logic                      rerun;
  logic [SRST_CNT_WIDTH-1:0] cnt_inc;

  assign req_valid = soft_rst_req && (soft_rst_mask != '0);
  // A request landing on the completion edge merges straight into the rerun.
  assign rerun_mask = pend_mask_q | (req_valid ? soft_rst_mask : '0);
  assign rerun      = pend_q || req_valid;
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // State register: all sequencer state and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= ASSERT;
      timer_q     <= '0;
      idx_q       <= '0;
      act_mask_q  <= '1;
      pend_q      <= 1'b0;
      pend_mask_q <= '0;
      rst_n_q     <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      act_mask_q  <= act_mask_d;
      pend_q      <= pend_d;
      pend_mask_q <= pend_mask_d;
      rst_n_q     <= rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic: RUN -> ASSERT -> RELEASE -> RUN, or back to ASSERT on rerun.
  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (req_valid) state_d = ASSERT;
      ASSERT:  if (timer_q == STRETCH_LAST) state_d = RELEASE;
      RELEASE: if (idx_q == IDX_LAST) state_d = rerun ? ASSERT : RUN;
      default: state_d = RUN;
    endcase
  end

  // Output and datapath logic: timer, release slots, queuing and counting.
  always_comb begin
    timer_d     = timer_q;
    idx_d       = idx_q;
    act_mask_d  = act_mask_q;
    pend_d      = pend_q;
    pend_mask_d = pend_mask_q;
    rst_n_d     = rst_n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;

    // Any request while a sequence runs is queued for one coalesced rerun.
    if (state_q != RUN && req_valid) begin
      pend_d      = 1'b1;
      pend_mask_d = pend_mask_q | soft_rst_mask;
    end

    unique case (state_q)
      RUN: begin
        if (req_valid) begin
          act_mask_d = soft_rst_mask;
          rst_n_d    = rst_n_q & ~soft_rst_mask;
          busy_d     = 1'b1;
          cnt_d      = cnt_inc;
          timer_d    = '0;
        end
      end

      ASSERT: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == STRETCH_LAST) begin
          timer_d = '0;
          idx_d   = '0;
          if (act_mask_q[0]) rst_n_d[0] = 1'b1;
        end
      end

      RELEASE: begin
        if (idx_q == IDX_LAST) begin
          // Completion edge: pulse done, then either idle or start the rerun.
          done_d = 1'b1;
          if (rerun) begin
            act_mask_d  = rerun_mask;
            rst_n_d     = rst_n_q & ~rerun_mask;
            cnt_d       = cnt_inc;
            pend_d      = 1'b0;
            pend_mask_d = '0;
            timer_d     = '0;
          end else begin
            busy_d = 1'b0;
          end
        end else if (timer_q == GAP_LAST) begin
          timer_d = '0;
          idx_d   = idx_q + 1'b1;
          for (int i = 0; i < N_RST_OUT; i++) begin
            if (IDX_W'(i) == idx_q + 1'b1 && act_mask_q[i]) rst_n_d[i] = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: ;
    endcase
  end

  assign rst_n_out    = rst_n_q;
  assign seq_busy     = busy_q;
  assign seq_done     = done_q;
  assign soft_rst_cnt = cnt_q;

endmodule

// File: tb/tb_kws_reset_sequencer.sv
// Scoreboard bench for kws_reset_sequencer. Each scenario pushes expected
// output snapshots, keyed by edge number, when it drives its stimulus, and
// pops and compares them as the DUT reaches those edges. A second instance
// with a 2-bit event counter exercises counter saturation.
module tb_kws_reset_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic [3:0] soft_rst_mask = 4'b0000;
  logic [3:0] rst_n_out;
  logic       seq_busy;
  logic       seq_done;
  logic [7:0] soft_rst_cnt;

  logic       w2_req = 1'b0;
  logic [3:0] w2_mask = 4'b0000;
  logic [3:0] w2_rst_n_out;
  logic       w2_busy;
  logic       w2_done;
  logic [1:0] w2_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_cnt = 0;

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   w2_cnt_q[$];

  kws_reset_sequencer #(
    .N_RST_OUT(4), .STRETCH_CYCLES(16), .GAP_CYCLES(8),
    .CNT_WIDTH(8), .SRST_CNT_WIDTH(8)
  ) u_dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .soft_rst_req (soft_rst_req),
    .soft_rst_mask(soft_rst_mask),
    .rst_n_out    (rst_n_out),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done),
    .soft_rst_cnt (soft_rst_cnt)
  );

  kws_reset_sequencer #(
    .N_RST_OUT(4), .STRETCH_CYCLES(2), .GAP_CYCLES(1),
    .CNT_WIDTH(4), .SRST_CNT_WIDTH(2)
  ) u_dut_w2 (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .soft_rst_req (w2_req),
    .soft_rst_mask(w2_mask),
    .rst_n_out    (w2_rst_n_out),
    .seq_busy     (w2_busy),
    .seq_done     (w2_done),
    .soft_rst_cnt (w2_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Edge counter: after posedge number k, cyc reads k at the following negedge.
  always @(posedge sys_clk) cyc++;

  function automatic void push_exp(int c, logic [3:0] r, logic b, logic d, logic [7:0] n);
    exp_t e;
    e.cyc = c; e.rst = r; e.busy = b; e.done = d; e.cnt = n;
    exp_q.push_back(e);
  endfunction

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      checks++;
      if (rst_n_out !== 4'b0000 || seq_busy !== 1'b1 || seq_done !== 1'b0 ||
          soft_rst_cnt !== 8'd0) begin
        errors++;
        $display("FAIL reset @%0d: got rst=%b busy=%b done=%b cnt=%0d, want rst=0000 busy=1 done=0 cnt=0",
                 cyc, rst_n_out, seq_busy, seq_done, soft_rst_cnt);
      end
    end
  endtask

  task automatic test_power_on();
    int   l;
    exp_t e;
    l = cyc;  // last edge that saw sys_rst_n low
    sys_rst_n = 1'b1;
    exp_cnt = 0;
    push_exp(l + 15, 4'b0000, 1, 0, 0);
    push_exp(l + 16, 4'b0001, 1, 0, 0);
    push_exp(l + 23, 4'b0001, 1, 0, 0);
    push_exp(l + 24, 4'b0011, 1, 0, 0);
    push_exp(l + 32, 4'b0111, 1, 0, 0);
    push_exp(l + 40, 4'b1111, 1, 0, 0);
    push_exp(l + 41, 4'b1111, 0, 1, 0);
    push_exp(l + 42, 4'b1111, 0, 0, 0);
    for (int t = 0; t < 45; t++) begin
      @(negedge sys_clk);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (rst_n_out !== e.rst || seq_busy !== e.busy || seq_done !== e.done || soft_rst_cnt !== e.cnt) begin
          errors++;
          $display("FAIL power_on @L+%0d: got rst=%b busy=%b done=%b cnt=%0d, want rst=%b busy=%b done=%b cnt=%0d",
                   cyc - l, rst_n_out, seq_busy, seq_done, soft_rst_cnt, e.rst, e.busy, e.done, e.cnt);
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL power_on timeout: %0d expectations never reached", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_masked_soft();
    int   r;
    exp_t e;
    r = cyc + 1;
    soft_rst_req = 1'b1; soft_rst_mask = 4'b1010;
    exp_cnt++;
    push_exp(r,      4'b0101, 1, 0, 8'(exp_cnt));
    push_exp(r + 23, 4'b0101, 1, 0, 8'(exp_cnt));
    push_exp(r + 24, 4'b0111, 1, 0, 8'(exp_cnt));
    push_exp(r + 39, 4'b0111, 1, 0, 8'(exp_cnt));
    push_exp(r + 40, 4'b1111, 1, 0, 8'(exp_cnt));
    push_exp(r + 41, 4'b1111, 0, 1, 8'(exp_cnt));
    push_exp(r + 42, 4'b1111, 0, 0, 8'(exp_cnt));
    for (int t = 0; t < 45; t++) begin
      @(negedge sys_clk);
      soft_rst_req = 1'b0; soft_rst_mask = 4'b0000;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (rst_n_out !== e.rst || seq_busy !== e.busy || seq_done !== e.done || soft_rst_cnt !== e.cnt) begin
          errors++;
          $display("FAIL masked_soft @R+%0d: got rst=%b busy=%b done=%b cnt=%0d, want rst=%b busy=%b done=%b cnt=%0d",
                   cyc - r, rst_n_out, seq_busy, seq_done, soft_rst_cnt, e.rst, e.busy, e.done, e.cnt);
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL masked_soft timeout: %0d expectations never reached", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_coalesce();
    int   r;
    int   base;
    exp_t e;
    r = cyc + 1;
    base = exp_cnt;
    soft_rst_req = 1'b1; soft_rst_mask = 4'b1010;
    exp_cnt = base + 2;
    push_exp(r,      4'b0101, 1, 0, 8'(base + 1));
    push_exp(r + 40, 4'b1111, 1, 0, 8'(base + 1));
    push_exp(r + 41, 4'b1010, 1, 1, 8'(base + 2));
    push_exp(r + 42, 4'b1010, 1, 0, 8'(base + 2));
    push_exp(r + 56, 4'b1010, 1, 0, 8'(base + 2));
    push_exp(r + 57, 4'b1011, 1, 0, 8'(base + 2));
    push_exp(r + 72, 4'b1011, 1, 0, 8'(base + 2));
    push_exp(r + 73, 4'b1111, 1, 0, 8'(base + 2));
    push_exp(r + 81, 4'b1111, 1, 0, 8'(base + 2));
    push_exp(r + 82, 4'b1111, 0, 1, 8'(base + 2));
    push_exp(r + 83, 4'b1111, 0, 0, 8'(base + 2));
    for (int t = 0; t < 86; t++) begin
      @(negedge sys_clk);
      // Queued requests at edges R+5 (mask 0001) and R+30 (mask 0100).
      soft_rst_req  = (cyc == r + 4) || (cyc == r + 29);
      soft_rst_mask = (cyc == r + 4) ? 4'b0001 : (cyc == r + 29) ? 4'b0100 : 4'b0000;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (rst_n_out !== e.rst || seq_busy !== e.busy || seq_done !== e.done || soft_rst_cnt !== e.cnt) begin
          errors++;
          $display("FAIL coalesce @R+%0d: got rst=%b busy=%b done=%b cnt=%0d, want rst=%b busy=%b done=%b cnt=%0d",
                   cyc - r, rst_n_out, seq_busy, seq_done, soft_rst_cnt, e.rst, e.busy, e.done, e.cnt);
        end
      end
    end
    soft_rst_req = 1'b0; soft_rst_mask = 4'b0000;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL coalesce timeout: %0d expectations never reached", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_seq();
    int   r;
    exp_t e;
    r = cyc + 1;
    soft_rst_req = 1'b1; soft_rst_mask = 4'b1010;
    push_exp(r,      4'b0101, 1, 0, 8'(exp_cnt + 1));
    push_exp(r + 19, 4'b0101, 1, 0, 8'(exp_cnt + 1));
    exp_cnt = 0;
    // Reset sampled at edge R+20, which becomes the new entry edge L.
    push_exp(r + 20, 4'b0000, 1, 0, 0);
    push_exp(r + 35, 4'b0000, 1, 0, 0);
    push_exp(r + 36, 4'b0001, 1, 0, 0);
    push_exp(r + 44, 4'b0011, 1, 0, 0);
    push_exp(r + 52, 4'b0111, 1, 0, 0);
    push_exp(r + 60, 4'b1111, 1, 0, 0);
    push_exp(r + 61, 4'b1111, 0, 1, 0);
    push_exp(r + 62, 4'b1111, 0, 0, 0);
    push_exp(r + 70, 4'b1111, 0, 0, 0);
    for (int t = 0; t < 73; t++) begin
      @(negedge sys_clk);
      // A queued request at R+5 must be discarded by the reset.
      soft_rst_req  = (cyc == r + 4);
      soft_rst_mask = (cyc == r + 4) ? 4'b0001 : 4'b0000;
      sys_rst_n     = !(cyc == r + 19);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (rst_n_out !== e.rst || seq_busy !== e.busy || seq_done !== e.done || soft_rst_cnt !== e.cnt) begin
          errors++;
          $display("FAIL reset_mid_seq @R+%0d: got rst=%b busy=%b done=%b cnt=%0d, want rst=%b busy=%b done=%b cnt=%0d",
                   cyc - r, rst_n_out, seq_busy, seq_done, soft_rst_cnt, e.rst, e.busy, e.done, e.cnt);
        end
      end
    end
    sys_rst_n = 1'b1; soft_rst_req = 1'b0; soft_rst_mask = 4'b0000;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL reset_mid_seq timeout: %0d expectations never reached", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_zero_mask();
    int   r;
    exp_t e;
    r = cyc + 1;
    soft_rst_req = 1'b1; soft_rst_mask = 4'b0000;
    push_exp(r,     4'b1111, 0, 0, 8'(exp_cnt));
    push_exp(r + 1, 4'b1111, 0, 0, 8'(exp_cnt));
    push_exp(r + 3, 4'b1111, 0, 0, 8'(exp_cnt));
    for (int t = 0; t < 5; t++) begin
      @(negedge sys_clk);
      soft_rst_req = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (rst_n_out !== e.rst || seq_busy !== e.busy || seq_done !== e.done || soft_rst_cnt !== e.cnt) begin
          errors++;
          $display("FAIL zero_mask @R+%0d: got rst=%b busy=%b done=%b cnt=%0d, want rst=%b busy=%b done=%b cnt=%0d",
                   cyc - r, rst_n_out, seq_busy, seq_done, soft_rst_cnt, e.rst, e.busy, e.done, e.cnt);
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL zero_mask timeout: %0d expectations never reached", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int exp_n;
    int waited;
    for (int k = 1; k <= 5; k++) begin
      w2_cnt_q.push_back((k > 3) ? 3 : k);
      @(negedge sys_clk);
      w2_req = 1'b1; w2_mask = 4'b0110;
      @(negedge sys_clk);
      w2_req = 1'b0; w2_mask = 4'b0000;
      exp_n = w2_cnt_q.pop_front();
      checks++;
      if (w2_cnt !== 2'(exp_n) || w2_busy !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back seq%0d: got cnt=%0d busy=%b, want cnt=%0d busy=1",
                 k, w2_cnt, w2_busy, exp_n);
      end
      waited = 0;
      while (w2_done !== 1'b1 && waited < 50) begin
        @(negedge sys_clk);
        waited++;
      end
      if (waited >= 50) begin
        checks++; errors++;
        $display("FAIL back_to_back seq%0d: done timeout", k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_masked_soft();
    test_coalesce();
    test_reset_mid_seq();
    test_zero_mask();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
